// File: rtl/mas_feed.sv
// -----------------------------------------------------------------------------
// mas_feed -- audio byte feeder for a serial shifter.
//
// A CPU enqueues audio bytes into a small circular FIFO. A four-state feeder
// pops one byte at a time, places it on sh_datain[15:8] and pulses sh_wr_n
// low for one cycle. It then waits for the shifter to report spi_busy and for
// that busy period to end before issuing the next byte. If the shifter never
// reports busy within TMO cycles, the byte is dropped and tmo_err is set.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   cpu_wdata  byte to enqueue
//   cpu_wr     one-cycle enqueue strobe
//   cpu_ctrl   shifter control bits, copied to sh_datain[5:0]
//   flush      one-cycle FIFO clear (also clears ovf / tmo_err)
//   level      FIFO occupancy, 0..DEPTH
//   full/empty FIFO flags
//   ovf        sticky: write attempted while full
//   tmo_err    sticky: shifter did not go busy after a strobe
//   sh_datain  {data byte, 2'b00, cpu_ctrl} to the shifter
//   sh_wr_n    active-low write strobe to the shifter
//   sh_status  shifter status: bit7 spi_busy, bit6 chip busy
// -----------------------------------------------------------------------------
module mas_feed #(
   parameter int DEPTH = 16,
   parameter int TMO   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [7:0]             cpu_wdata,
   input  logic                   cpu_wr,
   input  logic [5:0]             cpu_ctrl,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf,
   output logic                   tmo_err,
   output logic [15:0]            sh_datain,
   output logic                   sh_wr_n,
   input  logic [7:0]             sh_status
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TMO + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, START, DONE} state_e;

   state_e          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     level_q;
   logic            ovf_q, tmo_err_q;
   logic [7:0]      hold_q;
   logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;

   logic spi_busy, chip_busy;
   logic push, pop, tmo_hit;
   logic unused_status;

   assign spi_busy      = sh_status[7];
   assign chip_busy     = sh_status[6];
   assign unused_status = ^sh_status[5:0];

   assign full  = (level_q == (AW + 1)'(DEPTH));
   assign empty = (level_q == '0);

   // A write while full is refused even if a pop frees a slot in the same
   // cycle; flush discards both the incoming byte and any pending pop.
   assign push = cpu_wr && !full && !flush;

   // Chip busy is only consulted here, so a byte already in flight is
   // always carried through to the end of its busy period.
   assign pop  = (state_q == IDLE) && !empty && !spi_busy && !chip_busy && !flush;

   // Counter reaches TMO-1 on the TMO-th cycle spent in START.
   assign tmo_hit = (state_q == START) && !spi_busy && (tmo_cnt_q == TW'(TMO - 1));

   // ---------------------------------------------------------------- state reg
   // NOTE: every clocked process uses non-blocking assignments so all
   // registers see pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   // --------------------------------------------------------------- next state
   // NOTE: defaults at the top of every combinational process keep each
   // output assigned on all paths, so no latches are inferred.
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = '0;
      unique case (state_q)
         IDLE:  if (pop) state_d = ISSUE;
         ISSUE: state_d = START;
         START: begin
            if (spi_busy)     state_d = DONE;
            else if (tmo_hit) state_d = IDLE;
            else              tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
         DONE:  if (!spi_busy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      sh_wr_n = 1'b1;
      if (state_q == ISSUE) sh_wr_n = 1'b0;
   end

   assign sh_datain = {hold_q, 2'b00, cpu_ctrl};
   assign level     = level_q;
   assign ovf       = ovf_q;
   assign tmo_err   = tmo_err_q;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ovf_q     <= 1'b0;
         tmo_err_q <= 1'b0;
         hold_q    <= 8'h00;
      end else begin
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (!push && pop) level_q <= level_q - 1'b1;
         end

         // The holding register changes only on a pop, so the byte stays put
         // while the shifter latches it after the strobe.
         if (pop) hold_q <= mem_q[rd_ptr_q];

         if (flush)              ovf_q <= 1'b0;
         else if (cpu_wr && full) ovf_q <= 1'b1;

         if (flush)        tmo_err_q <= 1'b0;
         else if (tmo_hit) tmo_err_q <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; its contents are only ever read
   // behind the level counter, which is reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= cpu_wdata;
   end

endmodule
